id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register plus EX-stage operand selection for the 5-stage MIPS core.
- Captures decoded instruction fields from ID each cycle and forwards results from EX/MEM and MEM/WB to resolve RAW hazards.
- Drives the ALU operand, function and shift-amount inputs directly.
- Also flags load-use hazards for the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- RADDR, 5, register-address width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hold ID/EX contents
- flush  in  1  load bubble into ID/EX
- id_rd1  in  XLEN  register-file read data, rs
- id_rd2  in  XLEN  register-file read data, rt
- id_imm  in  XLEN  sign-extended immediate
- id_rs, id_rt, id_rd  in  RADDR  register specifiers
- id_shamt  in  5  shift amount field
- id_alucontrol  in  4  ALU function code (0 AND, 1 OR, 2 ADD, 4 AND-NOT, 5 OR-NOT, 6 SUB, 7 SLT, 8 SLL, 9 SRL)
- id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite  in  1  control bits
- mem_regwrite  in  1  EX/MEM writes a register
- mem_writereg  in  RADDR  EX/MEM destination
- mem_aluout  in  XLEN  EX/MEM ALU result
- wb_regwrite  in  1  MEM/WB writes a register
- wb_writereg  in  RADDR  MEM/WB destination
- wb_result  in  XLEN  MEM/WB write-back value
- alu_a, alu_b  out  XLEN  ALU operands
- alu_f  out  4  ALU function
- alu_shamt  out  5  ALU shift amount
- ex_writedata  out  XLEN  forwarded rt value for store
- ex_writereg  out  RADDR  destination (rd if regdst else rt)
- ex_regwrite, ex_memtoreg, ex_memwrite  out  1  registered control
- lu_hazard  out  1  load-use hazard detected

Behaviour:
- Register update priority per rising edge: reset > flush > stall > load.
  - reset: all ID/EX fields cleared to 0. Outputs after reset: alu_a=alu_b=0, alu_f=0, alu_shamt=0, ex_writedata=0, ex_writereg=0, all ex_* control=0, lu_hazard=0 (assuming both forward sources inactive).
  - flush: same clear as reset (bubble). flush overrides a concurrent stall.
  - stall (no flush): every field holds its value.
  - otherwise: all id_* fields captured; latency 1 cycle ID→EX.
- Forwarding (combinational from registered rs/rt and live mem_/wb_ inputs):
  - Per operand: if mem_regwrite and mem_writereg≠0 and mem_writereg==src → mem_aluout.
  - Else if wb_regwrite and wb_writereg≠0 and wb_writereg==src → wb_result.
  - Else registered rd1/rd2.
  - MEM has priority over WB when both match. Register 0 is never forwarded.
- alu_a = forwarded rs value.
- ex_writedata = forwarded rt value.
- alu_b = registered imm if registered alusrc=1, else forwarded rt value.
- alu_f and alu_shamt = registered alucontrol and shamt, unmodified.
- ex_writereg = registered rd if registered regdst=1, else registered rt. Registered, so a zero when bubbled.
- lu_hazard (combinational) = ex_memtoreg AND ex_writereg≠0 AND (id_rs==ex_writereg OR id_rt==ex_writereg).
  - Hazard unit responds with stall upstream and flush on this block the following edge.
  - This block never self-stalls.
- Bubble semantics: a bubble has regwrite=memwrite=memtoreg=0, so it never triggers forwarding downstream or memory writes.
- Reset asserted mid-stream: the next edge clears the register regardless of stall/flush; no partial state is retained.

Test Plan:
- Reset with stall=1, flush=1 for 2 cycles → all outputs 0, lu_hazard=0.
- Load id_rd1=0x10, id_rd2=0x20, rs=1, rt=2, alusrc=0, alucontrol=2, no forwards → next cycle alu_a=0x10, alu_b=0x20, alu_f=2.
- Same instruction with mem_regwrite=1, mem_writereg=1, mem_aluout=0xAA; wb_regwrite=1, wb_writereg=1, wb_result=0xBB; wb_writereg2 match on rt via wb_writereg=2 in a second cycle → alu_a=0xAA (MEM priority), then alu_b=0xBB.
- Forward target register 0 (mem_writereg=0, rs=0, id_rd1=0) with mem_aluout=0xFFFF → alu_a stays 0.
- EX holds lw (memtoreg=1, regdst=0, rt=5); ID presents rs=5 → lu_hazard=1. Assert flush next edge → ex_regwrite=0, ex_memtoreg=0, lu_hazard=0.
- Stall=1 for 3 cycles while id_* toggle → outputs frozen; stall+flush together → bubble; alusrc=1, imm=0xFFFFFFFC, shamt=4, alucontrol=8 → alu_b=0xFFFFFFFC, alu_shamt=4, alu_f=8.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use detection.
// Drives the ALU operand, function and shift-amount inputs directly.

module id_ex_fwd #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic [RADDR-1:0] src,
   input  logic [XLEN-1:0]  regval,
   input  logic             mem_regwrite,
   input  logic [RADDR-1:0] mem_writereg,
   input  logic [XLEN-1:0]  mem_aluout,
   input  logic             wb_regwrite,
   input  logic [RADDR-1:0] wb_writereg,
   input  logic [XLEN-1:0]  wb_result,
   output logic [XLEN-1:0]  val
);
   // Youngest producer wins; $0 is hardwired and never forwarded.
   always_comb begin
      val = regval;
      if (mem_regwrite && (mem_writereg != '0) && (mem_writereg == src))
         val = mem_aluout;
      else if (wb_regwrite && (wb_writereg != '0) && (wb_writereg == src))
         val = wb_result;
   end
endmodule

module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             flush,
   input  logic [XLEN-1:0]  id_rd1,
   input  logic [XLEN-1:0]  id_rd2,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [RADDR-1:0] id_rs,
   input  logic [RADDR-1:0] id_rt,
   input  logic [RADDR-1:0] id_rd,
   input  logic [4:0]       id_shamt,
   input  logic [3:0]       id_alucontrol,
   input  logic             id_alusrc,
   input  logic             id_regdst,
   input  logic             id_regwrite,
   input  logic             id_memtoreg,
   input  logic             id_memwrite,
   input  logic             mem_regwrite,
   input  logic [RADDR-1:0] mem_writereg,
   input  logic [XLEN-1:0]  mem_aluout,
   input  logic             wb_regwrite,
   input  logic [RADDR-1:0] wb_writereg,
   input  logic [XLEN-1:0]  wb_result,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [3:0]       alu_f,
   output logic [4:0]       alu_shamt,
   output logic [XLEN-1:0]  ex_writedata,
   output logic [RADDR-1:0] ex_writereg,
   output logic             ex_regwrite,
   output logic             ex_memtoreg,
   output logic             ex_memwrite,
   output logic             lu_hazard
);
   typedef struct packed {
      logic [XLEN-1:0]  rd1;
      logic [XLEN-1:0]  rd2;
      logic [XLEN-1:0]  imm;
      logic [RADDR-1:0] rs;
      logic [RADDR-1:0] rt;
      logic [RADDR-1:0] rd;
      logic [4:0]       shamt;
      logic [3:0]       alucontrol;
      logic             alusrc;
      logic             regdst;
      logic             regwrite;
      logic             memtoreg;
      logic             memwrite;
   } idex_t;

   idex_t d, q;

   assign d = '{rd1: id_rd1, rd2: id_rd2, imm: id_imm, rs: id_rs, rt: id_rt,
                rd: id_rd, shamt: id_shamt, alucontrol: id_alucontrol,
                alusrc: id_alusrc, regdst: id_regdst, regwrite: id_regwrite,
                memtoreg: id_memtoreg, memwrite: id_memwrite};

   // A bubble is the all-zero record, so it never forwards or writes memory.
   always_ff @(posedge clk) begin
      if (reset || flush)
         q <= '0;
      else if (!stall)
         q <= d;
   end

   logic [1:0][RADDR-1:0] fsrc;
   logic [1:0][XLEN-1:0]  fin, fout;

   assign fsrc = {q.rt, q.rs};
   assign fin  = {q.rd2, q.rd1};

   for (genvar g = 0; g < 2; g++) begin : g_fwd
      id_ex_fwd #(.XLEN(XLEN), .RADDR(RADDR)) u_fwd (
         .src          (fsrc[g]),
         .regval       (fin[g]),
         .mem_regwrite (mem_regwrite),
         .mem_writereg (mem_writereg),
         .mem_aluout   (mem_aluout),
         .wb_regwrite  (wb_regwrite),
         .wb_writereg  (wb_writereg),
         .wb_result    (wb_result),
         .val          (fout[g])
      );
   end

   assign alu_a        = fout[0];
   assign ex_writedata = fout[1];
   assign alu_b        = q.alusrc ? q.imm : fout[1];
   assign alu_f        = q.alucontrol;
   assign alu_shamt    = q.shamt;
   assign ex_writereg  = q.regdst ? q.rd : q.rt;
   assign ex_regwrite  = q.regwrite;
   assign ex_memtoreg  = q.memtoreg;
   assign ex_memwrite  = q.memwrite;

   // Load in EX whose target is read by the instruction now in ID.
   assign lu_hazard = ex_memtoreg && (ex_writereg != '0) &&
                      ((id_rs == ex_writereg) || (id_rt == ex_writereg));
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a spec-level model pushes expected EX outputs
// when stimulus is driven; they are popped and compared after the clock edge.

module tb_id_ex_stage;
   logic        clk = 1'b0;
   logic        reset, stall, flush;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
   logic [3:0]  id_alucontrol;
   logic        id_alusrc, id_regdst, id_regwrite, id_memtoreg, id_memwrite;
   logic        mem_regwrite, wb_regwrite;
   logic [4:0]  mem_writereg, wb_writereg;
   logic [31:0] mem_aluout, wb_result;
   logic [31:0] alu_a, alu_b, ex_writedata;
   logic [3:0]  alu_f;
   logic [4:0]  alu_shamt, ex_writereg;
   logic        ex_regwrite, ex_memtoreg, ex_memwrite, lu_hazard;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
      .id_alucontrol(id_alucontrol), .id_alusrc(id_alusrc), .id_regdst(id_regdst),
      .id_regwrite(id_regwrite), .id_memtoreg(id_memtoreg), .id_memwrite(id_memwrite),
      .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg), .mem_aluout(mem_aluout),
      .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_result(wb_result),
      .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_shamt(alu_shamt),
      .ex_writedata(ex_writedata), .ex_writereg(ex_writereg),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .ex_memwrite(ex_memwrite),
      .lu_hazard(lu_hazard)
   );

   typedef struct {
      logic [31:0] rd1, rd2, imm;
      logic [4:0]  rs, rt, rd, sh;
      logic [3:0]  f;
      logic        alusrc, regdst, rw, mtr, mw;
   } mreg_t;

   typedef struct {
      logic [31:0] a, b, wd;
      logic [3:0]  f;
      logic [4:0]  sh, wr;
      logic        rw, mtr, mw, lu;
   } exp_t;

   mreg_t m;
   exp_t  sbq[$];
   int    ntot = 0, npass = 0, nfail = 0;

   function automatic logic [31:0] fw(input logic [4:0] src, input logic [31:0] rv);
      if (mem_regwrite && mem_writereg != 0 && mem_writereg == src) return mem_aluout;
      if (wb_regwrite && wb_writereg != 0 && wb_writereg == src) return wb_result;
      return rv;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.a   = fw(m.rs, m.rd1);
      e.wd  = fw(m.rt, m.rd2);
      e.b   = m.alusrc ? m.imm : e.wd;
      e.f   = m.f;
      e.sh  = m.sh;
      e.wr  = m.regdst ? m.rd : m.rt;
      e.rw  = m.rw;
      e.mtr = m.mtr;
      e.mw  = m.mw;
      e.lu  = m.mtr && e.wr != 0 && (id_rs == e.wr || id_rt == e.wr);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      ntot++;
      assert (obs === expv) npass++;
      else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic check(input string step);
      exp_t e;
      if (sbq.size() == 0) begin
         chk({step, ":sb_empty"}, 32'd0, 32'd1);
         return;
      end
      e = sbq.pop_front();
      chk({step, ":alu_a"},        alu_a,        e.a);
      chk({step, ":alu_b"},        alu_b,        e.b);
      chk({step, ":alu_f"},        32'(alu_f),   32'(e.f));
      chk({step, ":alu_shamt"},    32'(alu_shamt), 32'(e.sh));
      chk({step, ":ex_writedata"}, ex_writedata, e.wd);
      chk({step, ":ex_writereg"},  32'(ex_writereg), 32'(e.wr));
      chk({step, ":ex_regwrite"},  32'(ex_regwrite), 32'(e.rw));
      chk({step, ":ex_memtoreg"},  32'(ex_memtoreg), 32'(e.mtr));
      chk({step, ":ex_memwrite"},  32'(ex_memwrite), 32'(e.mw));
      chk({step, ":lu_hazard"},    32'(lu_hazard), 32'(e.lu));
   endtask

   // Clock edge: model the register update, push the expectation, compare after the edge.
   task automatic tick(input string step);
      if (reset || flush) m = '{default: '0};
      else if (!stall)
         m = '{rd1: id_rd1, rd2: id_rd2, imm: id_imm, rs: id_rs, rt: id_rt, rd: id_rd,
               sh: id_shamt, f: id_alucontrol, alusrc: id_alusrc, regdst: id_regdst,
               rw: id_regwrite, mtr: id_memtoreg, mw: id_memwrite};
      sbq.push_back(model_out());
      @(posedge clk);
      #1;
      check(step);
   endtask

   // Combinational-only check: no edge, register contents unchanged.
   task automatic peek(input string step);
      sbq.push_back(model_out());
      #2;
      check(step);
   endtask

   task automatic set_instr(input logic [31:0] rd1, rd2, imm, input logic [4:0] rs, rt, rd,
                            sh, input logic [3:0] f, input logic alusrc, regdst, rw, mtr, mw);
      id_rd1 = rd1; id_rd2 = rd2; id_imm = imm; id_rs = rs; id_rt = rt; id_rd = rd;
      id_shamt = sh; id_alucontrol = f; id_alusrc = alusrc; id_regdst = regdst;
      id_regwrite = rw; id_memtoreg = mtr; id_memwrite = mw;
   endtask

   task automatic set_fwd(input logic mrw, input logic [4:0] mwr, input logic [31:0] mout,
                          input logic wrw, input logic [4:0] wwr, input logic [31:0] wres);
      mem_regwrite = mrw; mem_writereg = mwr; mem_aluout = mout;
      wb_regwrite = wrw; wb_writereg = wwr; wb_result = wres;
   endtask

   initial begin
      m = '{default: '0};
      reset = 1'b1; stall = 1'b1; flush = 1'b1;
      set_instr(32'h1111, 32'h2222, 32'h3333, 5'd3, 5'd4, 5'd6, 5'd7, 4'd6, 1, 1, 1, 1, 1);
      set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      tick("reset0");
      tick("reset1");

      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      set_instr(32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 5'd3, 5'd0, 4'd2, 0, 1, 1, 0, 0);
      tick("add_plain");

      set_fwd(1, 5'd1, 32'hAA, 1, 5'd1, 32'hBB);
      tick("fwd_mem_prio");
      wb_writereg = 5'd2;
      tick("fwd_wb_rt");

      set_instr(32'h0, 32'h20, 32'h0, 5'd0, 5'd2, 5'd3, 5'd0, 4'd2, 0, 1, 1, 0, 0);
      set_fwd(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0);
      tick("fwd_r0");

      set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
      set_instr(32'h100, 32'h0, 32'h8, 5'd3, 5'd5, 5'd0, 5'd0, 4'd2, 1, 0, 1, 1, 0);
      tick("lw_load");
      set_instr(32'h5, 32'h6, 32'h0, 5'd5, 5'd9, 5'd10, 5'd0, 4'd2, 0, 1, 1, 0, 0);
      peek("lu_detect");
      flush = 1'b1;
      tick("lu_flush");
      flush = 1'b0;

      set_instr(32'h77, 32'h88, 32'h1234, 5'd7, 5'd8, 5'd9, 5'd3, 4'd1, 1, 1, 1, 0, 1);
      set_fwd(1, 5'd8, 32'hC0DE, 1, 5'd7, 32'hBEEF);
      tick("pre_stall");
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         set_instr($urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom),
                   5'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
         tick($sformatf("stall%0d", i));
      end
      flush = 1'b1;
      tick("stall_flush");
      stall = 1'b0; flush = 1'b0;
      set_fwd(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);

      set_instr(32'h1, 32'h2, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd4, 5'd4, 4'd8, 1, 1, 1, 0, 0);
      tick("sll_imm");

      set_instr(32'h9, 32'hA, 32'h0, 5'd5, 5'd6, 5'd0, 5'd0, 4'd7, 0, 0, 1, 1, 1);
      tick("lw_rt");
      reset = 1'b1; stall = 1'b1;
      tick("reset_mid");
      reset = 1'b0; stall = 1'b0;

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
